// File: rtl/fu_alu_rs.sv
// ALU reservation station and dispatch controller.
// Buffers renamed ALU instructions, snoops the CDB for missing operands,
// dispatches one ready entry at a time to the FU over EN/finish and
// holds the result for the CDB arbiter under a valid/ready handshake.

// One station entry: operand capture, CDB snoop and readiness.
module fu_alu_rs_entry #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic             free,
    input  logic             set_disp,
    input  logic [3:0]       a_ctrl,
    input  logic [TAG_W-1:0] a_qj,
    input  logic [TAG_W-1:0] a_qk,
    input  logic [31:0]      a_vj,
    input  logic [31:0]      a_vk,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             valid,
    output logic             ready,
    output logic [3:0]       ctrl,
    output logic [31:0]      vj,
    output logic [31:0]      vk
);
    logic             disp;
    logic [TAG_W-1:0] qj, qk;
    logic             cdb_live;
    logic             hit_j, hit_k, a_hit_j, a_hit_k;

    // Tag 0 means "value present", so a broadcast of tag 0 never matches.
    assign cdb_live = cdb_valid & (cdb_tag != '0);
    assign hit_j    = cdb_live & valid & (qj == cdb_tag);
    assign hit_k    = cdb_live & valid & (qk == cdb_tag);
    // Bypass: an instruction being written this edge sees the broadcast too.
    assign a_hit_j  = cdb_live & (a_qj == cdb_tag);
    assign a_hit_k  = cdb_live & (a_qk == cdb_tag);

    assign ready = valid & ~disp & (qj == '0) & (qk == '0);

    // Entry state: allocate, snoop, mark dispatched, free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            disp  <= 1'b0;
            ctrl  <= '0;
            qj    <= '0;
            qk    <= '0;
            vj    <= '0;
            vk    <= '0;
        end else if (alloc) begin
            // alloc only targets a free entry, so it never overlaps free/set_disp
            valid <= 1'b1;
            disp  <= 1'b0;
            ctrl  <= a_ctrl;
            qj    <= a_hit_j ? '0 : a_qj;
            vj    <= a_hit_j ? cdb_data : a_vj;
            qk    <= a_hit_k ? '0 : a_qk;
            vk    <= a_hit_k ? cdb_data : a_vk;
        end else begin
            if (free) begin
                valid <= 1'b0;
                disp  <= 1'b0;
            end else if (set_disp) begin
                disp  <= 1'b1;
            end
            if (hit_j) begin
                qj <= '0;
                vj <= cdb_data;
            end
            if (hit_k) begin
                qk <= '0;
                vk <= cdb_data;
            end
        end
    end
endmodule

module fu_alu_rs #(
    parameter int DEPTH    = 2,
    parameter int TAG_W    = 4,
    parameter int TAG_BASE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_ctrl,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [TAG_W-1:0] issue_qk,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             fu_en,
    output logic [3:0]       fu_ctrl,
    output logic [31:0]      fu_a,
    output logic [31:0]      fu_b,
    input  logic             fu_finish,
    input  logic [31:0]      fu_res,
    input  logic             fu_overflow,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data,
    output logic             wb_overflow
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]             state;
    logic [IDX_W-1:0]       cur_idx;

    logic [DEPTH-1:0]            e_valid, e_ready;
    logic [DEPTH-1:0][3:0]       e_ctrl;
    logic [DEPTH-1:0][31:0]      e_vj, e_vk;

    logic [IDX_W-1:0]       free_idx, ready_idx;
    logic                   any_ready;
    logic                   issue_fire, dispatch, release_e;

    // Lowest free entry; the descending scan leaves the lowest index last.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (!e_valid[i]) free_idx = IDX_W'(i);
    end

    // Lowest ready entry for dispatch.
    always_comb begin
        ready_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (e_ready[i]) ready_idx = IDX_W'(i);
    end

    assign any_ready   = |e_ready;
    // Issue side depends only on registered entry state, never on wb_ready.
    assign issue_ready = ~&e_valid;
    assign issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
    assign issue_fire  = issue_valid & issue_ready;
    assign dispatch    = (state == S_IDLE) & any_ready;
    assign release_e   = (state == S_HOLD) & wb_ready;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_ent
            fu_alu_rs_entry #(.TAG_W(TAG_W)) u_ent (
                .clk       (clk),
                .rst       (rst),
                .alloc     (issue_fire & (free_idx == IDX_W'(g))),
                .free      (release_e & (cur_idx == IDX_W'(g))),
                .set_disp  (dispatch & (ready_idx == IDX_W'(g))),
                .a_ctrl    (issue_ctrl),
                .a_qj      (issue_qj),
                .a_qk      (issue_qk),
                .a_vj      (issue_vj),
                .a_vk      (issue_vk),
                .cdb_valid (cdb_valid),
                .cdb_tag   (cdb_tag),
                .cdb_data  (cdb_data),
                .valid     (e_valid[g]),
                .ready     (e_ready[g]),
                .ctrl      (e_ctrl[g]),
                .vj        (e_vj[g]),
                .vk        (e_vk[g])
            );
        end
    endgenerate

    // Dispatch FSM: one instruction in flight, result held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_idx     <= '0;
            fu_en       <= 1'b0;
            fu_ctrl     <= '0;
            fu_a        <= '0;
            fu_b        <= '0;
            wb_valid    <= 1'b0;
            wb_tag      <= '0;
            wb_data     <= '0;
            wb_overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_ready) begin
                        fu_en   <= 1'b1;
                        fu_ctrl <= e_ctrl[ready_idx];
                        fu_a    <= e_vj[ready_idx];
                        fu_b    <= e_vk[ready_idx];
                        cur_idx <= ready_idx;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    fu_en <= 1'b0;
                    if (fu_finish) begin
                        wb_data     <= fu_res;
                        wb_overflow <= fu_overflow;
                        wb_tag      <= TAG_W'(TAG_BASE) + TAG_W'(cur_idx);
                        wb_valid    <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fu_alu_rs.sv
// Bench for fu_alu_rs: a behavioural ALU FU with programmable latency,
// a scoreboard of expected write-backs, and one task per scenario.
module tb_fu_alu_rs;
    localparam int DEPTH = 2, TAG_W = 4, TAG_BASE = 1;
    localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             ovf;
    } wb_t;

    logic clk = 1'b0, rst = 1'b1;
    logic issue_valid = 1'b0, issue_ready;
    logic [3:0] issue_ctrl = '0;
    logic [TAG_W-1:0] issue_qj = '0, issue_qk = '0, issue_tag;
    logic [31:0] issue_vj = '0, issue_vk = '0;
    logic cdb_valid = 1'b0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic fu_en, fu_finish = 1'b0, fu_overflow = 1'b0;
    logic [3:0] fu_ctrl;
    logic [31:0] fu_a, fu_b, fu_res = '0;
    logic wb_valid, wb_ready = 1'b0, wb_overflow;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0] wb_data;

    int passed = 0, total = 0;
    wb_t sb[$];
    wb_t exp_wb;

    fu_alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TAG_BASE(TAG_BASE)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_ctrl(issue_ctrl),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_en(fu_en), .fu_ctrl(fu_ctrl), .fu_a(fu_a), .fu_b(fu_b),
        .fu_finish(fu_finish), .fu_res(fu_res), .fu_overflow(fu_overflow),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .wb_data(wb_data), .wb_overflow(wb_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic o;
        case (c)
            OP_ADD: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            OP_SUB: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            default: begin r = '0; o = 1'b0; end
        endcase
        return {o, r};
    endfunction

    function automatic wb_t mk(input int tag, input logic [31:0] d, input logic o);
        wb_t w;
        w.tag = TAG_W'(tag);
        w.data = d;
        w.ovf = o;
        return w;
    endfunction

    // Behavioural FU: finishes fu_lat cycles after seeing fu_en; not reset.
    int fu_lat = 1;
    int fu_cnt = 0;
    logic [3:0] fc = '0;
    logic [31:0] fa = '0, fb = '0;
    always @(posedge clk) begin
        fu_finish <= 1'b0;
        if (fu_en) begin
            fc <= fu_ctrl; fa <= fu_a; fb <= fu_b;
            if (fu_lat <= 1) begin
                {fu_overflow, fu_res} <= alu(fu_ctrl, fu_a, fu_b);
                fu_finish <= 1'b1;
            end else fu_cnt <= fu_lat - 1;
        end else if (fu_cnt > 0) begin
            fu_cnt <= fu_cnt - 1;
            if (fu_cnt == 1) begin
                {fu_overflow, fu_res} <= alu(fc, fa, fb);
                fu_finish <= 1'b1;
            end
        end
    end

    // Scoreboard: every accepted write-back must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            total++;
            if (sb.size() == 0)
                $display("FAIL wb_unexpected got tag=%0d data=%h ovf=%0b, required none", wb_tag, wb_data, wb_overflow);
            else begin
                exp_wb = sb.pop_front();
                if ({wb_tag, wb_data, wb_overflow} !== exp_wb)
                    $display("FAIL wb_result got tag=%0d data=%h ovf=%0b, required tag=%0d data=%h ovf=%0b",
                             wb_tag, wb_data, wb_overflow, exp_wb.tag, exp_wb.data, exp_wb.ovf);
                else passed++;
            end
        end
    end

    // Offer one instruction across the next edge; returns at edge+1.
    task automatic do_issue(input logic [3:0] c, input logic [TAG_W-1:0] qj, input logic [31:0] vj,
                            input logic [TAG_W-1:0] qk, input logic [31:0] vk);
        issue_valid = 1'b1; issue_ctrl = c;
        issue_qj = qj; issue_vj = vj; issue_qk = qk; issue_vk = vk;
        @(posedge clk); #1;
        issue_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({issue_ready, issue_tag} !== {1'b1, 4'd1})
            $display("FAIL reset_issue got ready=%0b tag=%0d, required 1/1", issue_ready, issue_tag);
        else passed++;
        @(posedge clk); #1;
        do_issue(OP_SUB, 4'd9, 32'd0, 4'd0, 32'd4);
        @(negedge clk);
        total++;
        if (issue_tag !== 4'd2) $display("FAIL pending_tag got %0d, required 2", issue_tag);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({issue_ready, issue_tag} !== {1'b1, 4'd1})
            $display("FAIL async_reset_issue got ready=%0b tag=%0d, required 1/1", issue_ready, issue_tag);
        else passed++;
        total++;
        if ({fu_en, fu_ctrl, fu_a, fu_b, wb_valid, wb_tag, wb_data, wb_overflow} !== '0)
            $display("FAIL async_reset_outs got en=%0b a=%h wb_valid=%0b wb_data=%h, required all 0",
                     fu_en, fu_a, wb_valid, wb_data);
        else passed++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_add_timing;
        wb_ready = 1'b1;
        sb.push_back(mk(1, 32'd12, 1'b0));
        do_issue(OP_ADD, 4'd0, 32'd5, 4'd0, 32'd7);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if (fu_en !== (k == 1)) $display("FAIL add_fu_en cycle %0d got %0b, required %0b", k, fu_en, k == 1);
            else passed++;
            total++;
            if (wb_valid !== (k == 3)) $display("FAIL add_wb_valid cycle %0d got %0b, required %0b", k, wb_valid, k == 3);
            else passed++;
            if (k == 1) begin
                total++;
                if ({fu_ctrl, fu_a, fu_b} !== {OP_ADD, 32'd5, 32'd7})
                    $display("FAIL add_operands got ctrl=%b a=%0d b=%0d, required 0001/5/7", fu_ctrl, fu_a, fu_b);
                else passed++;
            end
            if (k == 3) begin
                total++;
                if ({wb_tag, wb_data} !== {4'd1, 32'd12})
                    $display("FAIL add_wb got tag=%0d data=%0d, required 1/12", wb_tag, wb_data);
                else passed++;
            end
            if (k == 5) begin
                total++;
                if (issue_ready !== 1'b1) $display("FAIL add_ready_again got %0b, required 1", issue_ready);
                else passed++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cdb_wakeup;
        sb.push_back(mk(1, 32'd7, 1'b0));
        do_issue(OP_SUB, 4'd9, 32'hDEAD_BEEF, 4'd0, 32'd3);
        for (int k = 0; k <= 8; k++) begin
            if (k == 2) begin cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'd10; end
            if (k == 3) cdb_valid = 1'b0;
            @(negedge clk);
            total++;
            if (fu_en !== (k == 4)) $display("FAIL wake_fu_en cycle %0d got %0b, required %0b", k, fu_en, k == 4);
            else passed++;
            if (k == 4) begin
                total++;
                if ({fu_ctrl, fu_a, fu_b} !== {OP_SUB, 32'd10, 32'd3})
                    $display("FAIL wake_operands got ctrl=%b a=%0d b=%0d, required 0010/10/3", fu_ctrl, fu_a, fu_b);
                else passed++;
            end
            @(posedge clk); #1;
        end
        // Broadcast on the issue edge itself.
        sb.push_back(mk(1, 32'd7, 1'b0));
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'd10;
        do_issue(OP_SUB, 4'd9, 32'd0, 4'd0, 32'd3);
        cdb_valid = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if (fu_en !== (k == 1)) $display("FAIL bypass_fu_en cycle %0d got %0b, required %0b", k, fu_en, k == 1);
            else passed++;
            if (k == 1) begin
                total++;
                if ({fu_a, fu_b} !== {32'd10, 32'd3})
                    $display("FAIL bypass_operands got a=%0d b=%0d, required 10/3", fu_a, fu_b);
                else passed++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full;
        logic [TAG_W-1:0] tag_seen;
        int n;
        tag_seen = '0;
        n = 0;
        do_issue(OP_SUB, 4'd9, 32'd0, 4'd0, 32'd1);
        do_issue(OP_SUB, 4'd9, 32'd0, 4'd0, 32'd2);
        issue_valid = 1'b1; issue_ctrl = OP_ADD; issue_qj = '0; issue_qk = '0;
        issue_vj = 32'd100; issue_vk = 32'd100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({issue_ready, fu_en} !== 2'b00)
                $display("FAIL full_ready cycle %0d got ready=%0b en=%0b, required 0/0", k, issue_ready, fu_en);
            else passed++;
            if (k == 0) tag_seen = issue_tag;
            else begin
                total++;
                if (issue_tag !== tag_seen) $display("FAIL full_tag_stable got %0d, required %0d", issue_tag, tag_seen);
                else passed++;
            end
            @(posedge clk); #1;
        end
        issue_valid = 1'b0;
        sb.push_back(mk(1, 32'd19, 1'b0));
        sb.push_back(mk(2, 32'd18, 1'b0));
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'd20;
        @(posedge clk); #1 cdb_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (fu_en) begin
                total++;
                if ({fu_a, fu_b} !== {32'd20, (n == 0) ? 32'd1 : 32'd2})
                    $display("FAIL full_order dispatch %0d got a=%0d b=%0d, required 20/%0d", n, fu_a, fu_b, n + 1);
                else passed++;
                n++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (n !== 2) $display("FAIL full_dispatch_count got %0d, required 2", n);
        else passed++;
        @(negedge clk);
        total++;
        if ({issue_ready, issue_tag} !== {1'b1, 4'd1})
            $display("FAIL full_drained got ready=%0b tag=%0d, required 1/1", issue_ready, issue_tag);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        wb_ready = 1'b0;
        sb.push_back(mk(1, 32'h8000_0000, 1'b1));
        sb.push_back(mk(2, 32'd5, 1'b0));
        do_issue(OP_ADD, 4'd0, 32'h7FFF_FFFF, 4'd0, 32'd1);
        do_issue(OP_ADD, 4'd0, 32'd2, 4'd0, 32'd3);
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (wb_valid) got = 1'b1;
        end
        total++;
        if (!got) $display("FAIL bp_wb_timeout got wb_valid=0, required 1 within 20 cycles");
        else passed++;
        // Tag-0 broadcast must not touch the waiting ready entry.
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_data = 32'h0000_0BAD;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({wb_valid, wb_tag, wb_data, wb_overflow, fu_en} !== {1'b1, 4'd1, 32'h8000_0000, 1'b1, 1'b0})
                $display("FAIL bp_hold cycle %0d got v=%0b tag=%0d data=%h ovf=%0b en=%0b, required 1/1/80000000/1/0",
                         k, wb_valid, wb_tag, wb_data, wb_overflow, fu_en);
            else passed++;
            @(negedge clk);
        end
        cdb_valid = 1'b0;
        @(posedge clk); #1 wb_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fu_en) begin
                total++;
                if ({fu_a, fu_b} !== {32'd2, 32'd3})
                    $display("FAIL bp_second_operands got a=%h b=%h, required 2/3", fu_a, fu_b);
                else passed++;
                n++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (n !== 1) $display("FAIL bp_second_dispatch got %0d pulses, required 1", n);
        else passed++;
    endtask

    task automatic test_reset_in_wait;
        fu_lat = 4;
        wb_ready = 1'b1;
        do_issue(OP_ADD, 4'd0, 32'd1, 4'd0, 32'd1);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (fu_en !== 1'b1) $display("FAIL rw_dispatch got en=%0b, required 1", fu_en);
        else passed++;
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            total++;
            if ({wb_valid, fu_en, issue_ready, issue_tag} !== {1'b0, 1'b0, 1'b1, 4'd1})
                $display("FAIL rw_after_reset cycle %0d got v=%0b en=%0b ready=%0b tag=%0d, required 0/0/1/1",
                         k, wb_valid, fu_en, issue_ready, issue_tag);
            else passed++;
        end
        fu_lat = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_timing();
        test_cdb_wakeup();
        test_full();
        test_backpressure();
        test_reset_in_wait();
        total++;
        if (sb.size() != 0) $display("FAIL sb_drained got %0d pending, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
